// File: rtl/kbd_scancode_decoder_pkg.sv
// Purpose : shared constants and types for the PS/2 Set 2 scan-code decoder and the key decoders.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
// Contents: prefix/ignored byte constants, KEY_PAUSE, scdec_state_t, key_code_t and byte classifiers.
package kbd_pkg;

    // Prefix and special bytes of the Set 2 stream
    localparam logic [7:0] SC_PREFIX_EXT   = 8'hE0;
    localparam logic [7:0] SC_PREFIX_BRK   = 8'hF0;
    localparam logic [7:0] SC_PREFIX_PAUSE = 8'hE1;
    localparam logic [7:0] SC_FAKE_SHIFT   = 8'h12;
    localparam logic [2:0] SC_PAUSE_LEN    = 3'd7;

    // Keyboard housekeeping bytes that carry no key information in IDLE
    localparam logic [7:0] SC_IGN_ERR0   = 8'h00;
    localparam logic [7:0] SC_IGN_BAT    = 8'hAA;
    localparam logic [7:0] SC_IGN_ACK    = 8'hFA;
    localparam logic [7:0] SC_IGN_RESEND = 8'hFE;
    localparam logic [7:0] SC_IGN_ECHO   = 8'hEE;
    localparam logic [7:0] SC_IGN_ERR1   = 8'hFF;

    // {extended, code}; shared with the per-key toggle decoders
    typedef logic [8:0] key_code_t;

    localparam key_code_t KEY_PAUSE = 9'h177;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EXT     = 3'd1,
        ST_BRK     = 3'd2,
        ST_EXT_BRK = 3'd3,
        ST_PAUSE   = 3'd4
    } scdec_state_t;

    function automatic logic sc_is_ignored(input logic [7:0] b);
        return (b == SC_IGN_ERR0) || (b == SC_IGN_BAT) || (b == SC_IGN_ACK) ||
               (b == SC_IGN_RESEND) || (b == SC_IGN_ECHO) || (b == SC_IGN_ERR1);
    endfunction

    function automatic logic sc_is_prefix(input logic [7:0] b);
        return (b == SC_PREFIX_EXT) || (b == SC_PREFIX_BRK) || (b == SC_PREFIX_PAUSE);
    endfunction

endpackage

// File: rtl/kbd_scancode_decoder_if.sv
// Purpose : byte-in / key-event-out bundle of the scan-code decoder.
// Latency : n/a (wires only).
// Backpressure: none; din_new is a strobe and the event outputs are single-cycle pulses.
// Modports: master = decoder (consumes din/din_new, drives keyCode/make/brakee/seq_error);
//           slave  = byte source / event consumer.
interface kbd_scancode_decoder_if;
    import kbd_pkg::*;

    logic [7:0] din;
    logic       din_new;
    key_code_t  keyCode;
    logic       make;
    logic       brakee;
    logic       seq_error;

    modport master (
        input  din, din_new,
        output keyCode, make, brakee, seq_error
    );

    modport slave (
        output din, din_new,
        input  keyCode, make, brakee, seq_error
    );

endinterface

// File: rtl/kbd_scancode_decoder_timeout.sv
// Purpose : clearable saturating idle counter flagging an abandoned prefix sequence.
// Latency : expired is combinational from the count, high from the TIMEOUT_CYCLES-th idle cycle.
// Backpressure: none.
// Ports: clk, resetN (sync active-low), run (count enable, else cleared), clr (byte seen), expired.
module kbd_seq_timeout #(
    parameter int TIMEOUT_CYCLES = 100_000
) (
    input  logic clk,
    input  logic resetN,
    input  logic run,
    input  logic clr,
    output logic expired
);

    localparam int              CW       = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt;

    // Holds at CNT_LAST instead of wrapping, so a stalled owner still sees expiry
    always_ff @(posedge clk) begin
        if (!resetN) begin
            cnt <= '0;
        end else if (clr || !run) begin
            cnt <= '0;
        end else if (cnt != CNT_LAST) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign expired = run && (cnt == CNT_LAST);

endmodule

// File: rtl/kbd_scancode_decoder.sv
// Purpose : collapses PS/2 Set 2 multi-byte sequences (E0/F0/E1) into a 9-bit keyCode with make/brakee pulses.
// Latency : one register stage; event pulses follow the clock edge that samples the final byte.
// Backpressure: none; every din_new byte is consumed, outputs are one-cycle pulses.
// Ports: clk, resetN (sync active-low), kbd (master modport: din/din_new in, keyCode/make/brakee/seq_error out).
// Option: define KBD_PAUSE_KEY_EN to report the Pause key (make 9'h177 then brakee 9'h177 next cycle);
//         otherwise the E1 sequence is swallowed silently.
module kbd_scancode_decoder
    import kbd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100_000
) (
    input  logic                         clk,
    input  logic                         resetN,
    kbd_scancode_decoder_if.master       kbd
);

    scdec_state_t state, state_n;
    logic [2:0]   pause_cnt, pause_cnt_n;
    key_code_t    key_q, key_n;
    logic         make_q, make_n;
    logic         brk_q, brk_n;
    logic         err_q, err_n;
    logic         tmo_expired;
`ifdef KBD_PAUSE_KEY_EN
    logic         pause_brk_q, pause_brk_n;
`endif

    kbd_seq_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .resetN  (resetN),
        .run     (state != ST_IDLE),
        .clr     (kbd.din_new),
        .expired (tmo_expired)
    );

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state     <= ST_IDLE;
            pause_cnt <= '0;
            key_q     <= '0;
            make_q    <= 1'b0;
            brk_q     <= 1'b0;
            err_q     <= 1'b0;
`ifdef KBD_PAUSE_KEY_EN
            pause_brk_q <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            pause_cnt <= pause_cnt_n;
            key_q     <= key_n;
            make_q    <= make_n;
            brk_q     <= brk_n;
            err_q     <= err_n;
`ifdef KBD_PAUSE_KEY_EN
            pause_brk_q <= pause_brk_n;
`endif
        end
    end

    always_comb begin
        state_n     = state;
        pause_cnt_n = pause_cnt;
        key_n       = key_q;
        make_n      = 1'b0;
        brk_n       = 1'b0;
        err_n       = 1'b0;
`ifdef KBD_PAUSE_KEY_EN
        pause_brk_n = 1'b0;
`endif

        // A byte arriving in the expiry cycle takes priority over the timeout
        if (kbd.din_new) begin
            case (state)
                ST_IDLE: begin
                    if (kbd.din == SC_PREFIX_EXT) begin
                        state_n = ST_EXT;
                    end else if (kbd.din == SC_PREFIX_BRK) begin
                        state_n = ST_BRK;
                    end else if (kbd.din == SC_PREFIX_PAUSE) begin
                        state_n     = ST_PAUSE;
                        pause_cnt_n = SC_PAUSE_LEN;
                    end else if (!sc_is_ignored(kbd.din)) begin
                        make_n = 1'b1;
                        key_n  = {1'b0, kbd.din};
                    end
                end
                ST_EXT: begin
                    state_n = ST_IDLE;
                    if (kbd.din == SC_PREFIX_BRK) begin
                        state_n = ST_EXT_BRK;
                    end else if (sc_is_prefix(kbd.din)) begin
                        err_n = 1'b1;
                    end else if (kbd.din != SC_FAKE_SHIFT) begin
                        make_n = 1'b1;
                        key_n  = {1'b1, kbd.din};
                    end
                end
                ST_BRK: begin
                    state_n = ST_IDLE;
                    if (sc_is_prefix(kbd.din)) begin
                        err_n = 1'b1;
                    end else begin
                        brk_n = 1'b1;
                        key_n = {1'b0, kbd.din};
                    end
                end
                ST_EXT_BRK: begin
                    state_n = ST_IDLE;
                    if (sc_is_prefix(kbd.din)) begin
                        err_n = 1'b1;
                    end else if (kbd.din != SC_FAKE_SHIFT) begin
                        brk_n = 1'b1;
                        key_n = {1'b1, kbd.din};
                    end
                end
                ST_PAUSE: begin
                    // Byte contents are irrelevant; only the count keeps alignment
                    pause_cnt_n = pause_cnt - 3'd1;
                    if (pause_cnt == 3'd1) begin
                        state_n = ST_IDLE;
`ifdef KBD_PAUSE_KEY_EN
                        make_n      = 1'b1;
                        key_n       = KEY_PAUSE;
                        pause_brk_n = 1'b1;
`endif
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end else if (tmo_expired) begin
            state_n = ST_IDLE;
            err_n   = 1'b1;
        end

`ifdef KBD_PAUSE_KEY_EN
        // Pause has no break code, so its release is synthesised one cycle later.
        // PS/2 byte spacing makes a colliding event impossible in practice; if one
        // ever appears it is dropped so the Pause release is never lost.
        if (pause_brk_q) begin
            key_n  = KEY_PAUSE;
            brk_n  = 1'b1;
            make_n = 1'b0;
            err_n  = 1'b0;
        end
`endif
    end

    assign kbd.keyCode   = key_q;
    assign kbd.make      = make_q;
    assign kbd.brakee    = brk_q;
    assign kbd.seq_error = err_q;

endmodule
